// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, stop-length encodings and
// small helpers used by the TX serializer (and later the RX side).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_0P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;
  localparam logic [1:0] STOP_1P5 = 2'b11;

  localparam int UART_MIN_DIV = 16;

  // Parity steals the MSB slot, so enabling it removes one data bit.
  function automatic logic [3:0] data_bits(input logic wdlen, input logic pce);
    return 4'd8 + {3'd0, wdlen} - {3'd0, pce};
  endfunction

  function automatic logic [8:0] data_mask(input logic [3:0] nbits);
    case (nbits)
      4'd7:    return 9'h07F;
      4'd8:    return 9'h0FF;
      default: return 9'h1FF;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_done pulses on the final clock of
// each loaded period and stays low until the next load.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DIV_WD-1:0] period,
  output logic              bit_done
);

  localparam logic [DIV_WD-1:0] ONE = {{(DIV_WD-1){1'b0}}, 1'b1};

  logic [DIV_WD-1:0] cnt;
  logic              active;

  assign bit_done = active && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= period - ONE;
      active <= 1'b1;
    end else if (bit_done) begin
      active <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit serializer: pops FIFO words and shifts out start/data/parity/
// stop frames using the configuration latched at each handshake.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DIV_WD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_te,
  input  logic [11:0] cfg_mantissa,
  input  logic [3:0]  cfg_fraction,
  input  logic        cfg_wdlen,
  input  logic        cfg_pce,
  input  logic        cfg_ps,
  input  logic [1:0]  cfg_stoplen,
  input  logic [8:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tc_clr,
  output logic        sr_tc,
  output logic        tx_busy,
  output logic        uart_txd
);

  tx_state_e         state;
  logic [3:0]        bit_cnt;
  logic [8:0]        shift_q;
  logic [DIV_WD-1:0] per_q;
  logic              wdlen_q;
  logic              pce_q;
  logic              par_q;
  logic [1:0]        stop_q;
  logic [DIV_WD-1:0] div_cfg;
  logic [DIV_WD-1:0] div_eff;
  logic [DIV_WD-1:0] load_val;
  logic [3:0]        nd_new;
  logic [3:0]        nd_q;
  logic [8:0]        data_masked;
  logic              bit_done;
  logic              baud_load;
  logic              two_part;
  logic              stop_last;
  logic              hs;

  assign div_cfg     = DIV_WD'({cfg_mantissa, cfg_fraction});
  assign div_eff     = (div_cfg < DIV_WD'(UART_MIN_DIV)) ? DIV_WD'(UART_MIN_DIV) : div_cfg;
  assign nd_new      = data_bits(cfg_wdlen, cfg_pce);
  assign nd_q        = data_bits(wdlen_q, pce_q);
  assign data_masked = tx_data & data_mask(nd_new);

  // Two-stop and 1.5-stop frames split STOP into two timed parts.
  always_comb begin
    two_part = 1'b0;
    case (stop_q)
      STOP_1, STOP_0P5: two_part = 1'b0;
      STOP_2, STOP_1P5: two_part = 1'b1;
      default:          two_part = 1'b0;
    endcase
  end

  assign stop_last = (state == STOP) && bit_done && (!two_part || (bit_cnt == 4'd1));
  assign tx_ready  = !rst && cfg_te && ((state == IDLE) || stop_last);
  assign hs        = tx_valid && tx_ready;
  assign baud_load = hs || (bit_done && !stop_last);

  always_comb begin
    load_val = per_q;
    if (hs) begin
      load_val = div_eff;
    end else if ((state == STOP) && (stop_q == STOP_1P5)) begin
      load_val = per_q >> 1;
    end
  end

  uart_baud_gen #(.DIV_WD(DIV_WD)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (baud_load),
    .period   (load_val),
    .bit_done (bit_done)
  );

  // A handshake always wins: it may arrive in IDLE or on the final STOP clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift_q  <= 9'd0;
      per_q    <= '0;
      wdlen_q  <= 1'b0;
      pce_q    <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= STOP_1;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (hs) begin
      state    <= START;
      bit_cnt  <= 4'd0;
      shift_q  <= data_masked;
      per_q    <= div_eff;
      wdlen_q  <= cfg_wdlen;
      pce_q    <= cfg_pce;
      par_q    <= (^data_masked) ^ cfg_ps;
      stop_q   <= cfg_stoplen;
      uart_txd <= 1'b0;
      tx_busy  <= 1'b1;
    end else if (bit_done) begin
      case (state)
        START: begin
          state    <= DATA;
          uart_txd <= shift_q[0];
        end
        DATA: begin
          if (bit_cnt == nd_q - 4'd1) begin
            bit_cnt <= 4'd0;
            if (pce_q) begin
              state    <= PARITY;
              uart_txd <= par_q;
            end else begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end
          end else begin
            bit_cnt  <= bit_cnt + 4'd1;
            shift_q  <= shift_q >> 1;
            uart_txd <= shift_q[1];
          end
        end
        PARITY: begin
          state    <= STOP;
          uart_txd <= 1'b1;
        end
        STOP: begin
          if (stop_last) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            bit_cnt <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_tc <= 1'b1;
    end else if (stop_last && !hs) begin
      sr_tc <= 1'b1;
    end else if (tc_clr || hs) begin
      sr_tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: expected line segments are queued at
// each handshake and compared clock by clock against the serial output.
module tb_uart_tx_core;

  logic        clk;
  logic        rst;
  logic        cfg_te;
  logic [11:0] cfg_mantissa;
  logic [3:0]  cfg_fraction;
  logic        cfg_wdlen;
  logic        cfg_pce;
  logic        cfg_ps;
  logic [1:0]  cfg_stoplen;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tc_clr;
  logic        sr_tc;
  logic        tx_busy;
  logic        uart_txd;

  typedef struct {
    logic lvl;
    int   len;
    int   kind;
    int   idx;
  } seg_t;

  seg_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  uart_tx_core #(.DIV_WD(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_te       (cfg_te),
    .cfg_mantissa (cfg_mantissa),
    .cfg_fraction (cfg_fraction),
    .cfg_wdlen    (cfg_wdlen),
    .cfg_pce      (cfg_pce),
    .cfg_ps       (cfg_ps),
    .cfg_stoplen  (cfg_stoplen),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tc_clr       (tc_clr),
    .sr_tc        (sr_tc),
    .tx_busy      (tx_busy),
    .uart_txd     (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_cfg(input logic te, input logic [11:0] m, input logic [3:0] f,
                         input logic wd, input logic pce, input logic ps, input logic [1:0] sl);
    cfg_te = te; cfg_mantissa = m; cfg_fraction = f;
    cfg_wdlen = wd; cfg_pce = pce; cfg_ps = ps; cfg_stoplen = sl;
  endtask

  // Reference frame model built from the bench's own view of the configuration.
  task automatic push_expected(input logic [8:0] d);
    int   p;
    int   nd;
    int   stop_len;
    logic par;
    p = int'({cfg_mantissa, cfg_fraction});
    if (p < 16) p = 16;
    nd = 8 + int'(cfg_wdlen) - int'(cfg_pce);
    par = cfg_ps;
    for (int i = 0; i < nd; i++) par = par ^ d[i];
    exp_q.push_back('{1'b0, p, 0, 0});
    for (int i = 0; i < nd; i++) exp_q.push_back('{d[i], p, 1, i});
    if (cfg_pce) exp_q.push_back('{par, p, 2, 0});
    case (cfg_stoplen)
      2'b10:   stop_len = 2 * p;
      2'b11:   stop_len = p + p / 2;
      default: stop_len = p;
    endcase
    exp_q.push_back('{1'b1, stop_len, 3, 0});
  endtask

  task automatic push_word(input logic [8:0] d, input bit track, output int hs_at, output bit ok);
    int w;
    ok = 1'b0; hs_at = -1; w = 0;
    tx_data = d; tx_valid = 1'b1;
    #1;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk); #1; w++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL handshake_%h: tx_ready=%b required 1", d, tx_ready);
    end else begin
      hs_at = cyc + 1;
      ok = 1'b1;
      @(posedge clk);
      if (track) push_expected(d);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic run_monitor(input int nseg, output int tc_high);
    int   done;
    int   left;
    int   bad;
    int   idle;
    seg_t cur;
    done = 0; left = 0; bad = 0; idle = 0; tc_high = 0;
    cur = '{1'b1, 0, 0, 0};
    while (done < nseg) begin
      @(negedge clk);
      if (left == 0) begin
        if (exp_q.size() == 0) begin
          idle++;
          if (idle > 3000) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL monitor_timeout: %0d segments seen, required %0d", done, nseg);
            break;
          end
          continue;
        end
        cur = exp_q.pop_front();
        left = cur.len; bad = 0; idle = 0;
      end
      if (uart_txd !== cur.lvl) bad++;
      if (sr_tc === 1'b1) tc_high++;
      left--;
      if (left == 0) begin
        done++;
        n_cmp++;
        if (bad != 0) begin
          n_fail++;
          $display("[TB] FAIL line_kind%0d_idx%0d: %0d of %0d clocks wrong, required all at %b",
                   cur.kind, cur.idx, bad, cur.len, cur.lvl);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 9'd0; tc_clr = 1'b0;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (uart_txd !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_txd: got %b required 1", uart_txd); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b required 0", tx_ready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", tx_busy); end
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tc: got %b required 1", sr_tc); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_ready: got %b required 1", tx_ready); end
    @(negedge clk);
  endtask

  task automatic test_8n1();
    int h; bit ok; int tch;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    fork
      push_word(9'h055, 1'b1, h, ok);
      run_monitor(10, tch);
    join
    n_cmp++; if (tch != 0) begin n_fail++; $display("[TB] FAIL 8n1_tc_during_frame: %0d clocks high, required 0", tch); end
    n_cmp++; if (tx_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL 8n1_busy_last_stop: got %b required 1", tx_busy); end
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL 8n1_tc_rise: got %b required 1", sr_tc); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL 8n1_busy_end: got %b required 0", tx_busy); end
  endtask

  task automatic test_9bit_odd();
    int h; bit ok; int tch;
    set_cfg(1'b1, 12'd2, 4'd0, 1'b1, 1'b1, 1'b1, 2'b10);
    fork
      push_word(9'h0F3, 1'b1, h, ok);
      run_monitor(11, tch);
    join
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL 9o2_tc_rise: got %b required 1", sr_tc); end
  endtask

  task automatic test_formats();
    int h; bit ok; int tch;
    set_cfg(1'b1, 12'd1, 4'd4, 1'b0, 1'b1, 1'b0, 2'b11);
    fork
      push_word(9'h1B7, 1'b1, h, ok);
      run_monitor(10, tch);
    join
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL 7e15_tc_rise: got %b required 1", sr_tc); end
  endtask

  task automatic test_back_to_back();
    int h1; int h2; bit ok1; bit ok2; int tch;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    fork
      begin
        push_word(9'h0A5, 1'b1, h1, ok1);
        push_word(9'h13C, 1'b1, h2, ok2);
      end
      run_monitor(20, tch);
    join
    n_cmp++; if (h2 != h1 + 160) begin n_fail++; $display("[TB] FAIL b2b_gap: second handshake at +%0d, required +160", h2 - h1); end
    n_cmp++; if (tch != 0) begin n_fail++; $display("[TB] FAIL b2b_tc_between: %0d clocks high, required 0", tch); end
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_tc_rise: got %b required 1", sr_tc); end
  endtask

  task automatic test_cfg_change();
    int h1; int h2; bit ok1; bit ok2; int tch;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    fork
      begin
        push_word(9'h0E1, 1'b1, h1, ok1);
        cfg_mantissa = 12'd3;
        push_word(9'h02D, 1'b1, h2, ok2);
      end
      run_monitor(20, tch);
    join
    n_cmp++; if (h2 != h1 + 160) begin n_fail++; $display("[TB] FAIL cfg_first_len: second handshake at +%0d, required +160", h2 - h1); end
    @(negedge clk);
    set_cfg(1'b1, 12'd0, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00);
    fork
      push_word(9'h0FF, 1'b1, h1, ok1);
      run_monitor(10, tch);
    join
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_tc_rise: got %b required 1", sr_tc); end
  endtask

  task automatic test_te_drop();
    int h; bit ok; int tch; int rdy_hi;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    rdy_hi = 0;
    fork
      begin
        push_word(9'h0B2, 1'b1, h, ok);
        tx_data = 9'h111; tx_valid = 1'b1;
        repeat (40) @(negedge clk);
        cfg_te = 1'b0;
        while (cyc < h + 159) begin
          @(negedge clk); #1;
          if (tx_ready === 1'b1) rdy_hi++;
        end
        tc_clr = 1'b1;
        @(negedge clk);
        tc_clr = 1'b0;
        #1;
        n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL te_tc_set_wins: got %b required 1", sr_tc); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL te_busy_end: got %b required 0", tx_busy); end
        repeat (5) begin
          if (tx_ready === 1'b1) rdy_hi++;
          @(negedge clk); #1;
        end
        n_cmp++; if (rdy_hi != 0) begin n_fail++; $display("[TB] FAIL te_ready_low: %0d clocks high, required 0", rdy_hi); end
        tc_clr = 1'b1;
        @(negedge clk);
        tc_clr = 1'b0;
        #1;
        n_cmp++; if (sr_tc !== 1'b0) begin n_fail++; $display("[TB] FAIL te_tc_clear: got %b required 0", sr_tc); end
        tx_valid = 1'b0;
        cfg_te = 1'b1;
      end
      run_monitor(10, tch);
    join
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int h; bit ok; int tch;
    set_cfg(1'b1, 12'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    push_word(9'h000, 1'b0, h, ok);
    repeat (20) @(negedge clk);
    n_cmp++; if (uart_txd !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_line_low: got %b required 0", uart_txd); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (uart_txd !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_txd: got %b required 1", uart_txd); end
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_tc: got %b required 1", sr_tc); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b required 0", tx_busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      push_word(9'h0C3, 1'b1, h, ok);
      run_monitor(10, tch);
    join
    n_cmp++; if (tch != 0) begin n_fail++; $display("[TB] FAIL post_rst_tc_frame: %0d clocks high, required 0", tch); end
    @(negedge clk);
    n_cmp++; if (sr_tc !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_tc_rise: got %b required 1", sr_tc); end
  endtask

  initial begin
    $display("[TB] uart_tx_core bench start");
    test_reset();
    test_8n1();
    test_9bit_odd();
    test_formats();
    test_back_to_back();
    test_cfg_change();
    test_te_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
